async_fifo: RTL and testbench
=============================

ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 3, storage address width; ptr_width, default 4, pointer width (ADDR_WIDTH+1); DATA_WIDTH, default 8, word width; DATA_DEPTH, default 6, usable capacity in words (1..2^ADDR_WIDTH); num_stages, default 2, pointer cross-publication delay in clock cycles (>=1).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous active-low reset.
REQ-005 W_INC  input  1  write request for the current cycle.
REQ-006 WR_DATA  input  DATA_WIDTH  write word.
REQ-007 R_INC  input  1  read request (pop) for the current cycle.
REQ-008 RD_DATA  output  DATA_WIDTH  word at head of queue (show-ahead).
REQ-009 FULL  output  1  no write accepted while high.
REQ-010 EMPTY  output  1  no read accepted while high.

Function
REQ-011 Storage SHALL be DATA_DEPTH words; slot address = pointer mod DATA_DEPTH.
REQ-012 Write and read pointers SHALL be ptr_width-bit counters over 0..2*DATA_DEPTH-1, wrapping to 0 after 2*DATA_DEPTH-1.
REQ-013 Write accepted at a rising edge when W_INC=1 and FULL=0: WR_DATA stored at write slot, write pointer +1.
REQ-014 Read accepted at a rising edge when R_INC=1 and EMPTY=0: read pointer +1; popped word not cleared.
REQ-015 W_INC while FULL=1 and R_INC while EMPTY=1 SHALL be ignored (no pointer, storage or flag change).
REQ-016 Simultaneous accepted read and write in the same edge SHALL both take effect.
REQ-017 Each pointer SHALL be published to the opposite side through a num_stages-deep register chain; the published copy equals the pointer value num_stages edges earlier.
REQ-018 EMPTY SHALL be combinational: 1 when read pointer equals published write pointer.
REQ-019 FULL SHALL be combinational: 1 when (write pointer - published read pointer) mod 2*DATA_DEPTH equals DATA_DEPTH.
REQ-020 Consequence (num_stages=2): write at edge k -> EMPTY falls after edge k+2; read from full at edge k -> FULL falls after edge k+2; FULL rises right after the filling write; EMPTY rises right after the emptying read.
REQ-021 RD_DATA SHALL be combinational storage[read slot]; valid data whenever EMPTY=0.
REQ-022 FIFO order SHALL be preserved across slot wrap (DATA_DEPTH-1 -> 0) and pointer wrap.

Reset
REQ-023 RST=0 SHALL immediately, without clock, clear both pointers, all publish-chain stages and all storage words to 0.
REQ-024 During and after reset: EMPTY=1, FULL=0, RD_DATA=0; contents before reset mid-operation are lost.
REQ-025 First edge after RST rises SHALL operate normally.

Verification (defaults)
REQ-026 Reset: RST=0 -> EMPTY=1, FULL=0, RD_DATA=0x00 with no clock running.
REQ-027 Single write 0xA5 at edge k, R_INC=0 -> EMPTY=1 after edges k, k+1; EMPTY=0 and RD_DATA=0xA5 after edge k+2.
REQ-028 Writes 0x01..0x09 on 9 consecutive edges, no reads -> FULL=1 right after 6th write; 0x07..0x09 dropped; EMPTY=0.
REQ-029 From REQ-028 state, 7 consecutive R_INC edges -> RD_DATA 0x01..0x06 in order; EMPTY=1 right after 6th read; 7th read ignored; FULL=0 two edges after 1st read.
REQ-030 Interleaved write/read of 0x10..0x1D (14 words), simultaneous W_INC/R_INC on some edges -> read order exactly 0x10..0x1D across slot and pointer wrap.
REQ-031 3 words queued, RST pulsed low mid-cycle -> EMPTY=1, FULL=0, RD_DATA=0x00 at once; subsequent write 0x3C readable as first word.

Source files
------------

// File: rtl/async_fifo_if.sv
// async_fifo_if -- handshake/data bundle for async_fifo.
//   W_INC   : write request for the current cycle
//   WR_DATA : write word
//   R_INC   : pop request for the current cycle
//   RD_DATA : head-of-queue word (show-ahead)
//   FULL    : writes are ignored while high
//   EMPTY   : pops are ignored while high
// The master drives the requests. The slave (the FIFO) drives the data
// and status back.
interface async_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  W_INC;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  R_INC;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  FULL;
    logic                  EMPTY;

    modport master (output W_INC, WR_DATA, R_INC, input RD_DATA, FULL, EMPTY);
    modport slave  (input W_INC, WR_DATA, R_INC, output RD_DATA, FULL, EMPTY);
endinterface

// File: rtl/async_fifo.sv
// async_fifo -- single-clock FIFO whose pointers reach the opposite side
// through a num_stages-deep register chain. Each side sees the other side's
// pointer as it was num_stages edges earlier. This gives the FULL/EMPTY
// release latency of an async FIFO, and the whole block runs on one clock.
//
// Ports:
//   CLK : clock; all state updates on the rising edge
//   RST : asynchronous active-low reset; clears pointers, chains and storage
//   bus : async_fifo_if.slave carrying W_INC/WR_DATA/R_INC/RD_DATA/FULL/EMPTY
//
// Pointers count 0..2*DATA_DEPTH-1. The extra lap distinguishes the full
// state from the empty state even when DATA_DEPTH is not a power of two.
module async_fifo #(
    parameter int ADDR_WIDTH = 3,
    parameter int ptr_width  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 6,
    parameter int num_stages = 2
) (
    input  logic          CLK,
    input  logic          RST,
    async_fifo_if.slave   bus
);
    localparam logic [ptr_width-1:0] PTR_LAST  = ptr_width'(2 * DATA_DEPTH - 1);
    localparam logic [ptr_width-1:0] PTR_DEPTH = ptr_width'(DATA_DEPTH);
    localparam logic [ptr_width:0]   DIFF_SPAN = (ptr_width + 1)'(2 * DATA_DEPTH);
    localparam logic [ptr_width:0]   DIFF_FULL = (ptr_width + 1)'(DATA_DEPTH);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [ptr_width-1:0]  wptr, rptr;
    logic [ptr_width-1:0]  wq [num_stages];   // write pointer as seen by the read side
    logic [ptr_width-1:0]  rq [num_stages];   // read pointer as seen by the write side
    logic [ptr_width-1:0]  wsync, rsync;
    logic [ADDR_WIDTH-1:0] wslot, rslot;
    logic [ptr_width:0]    diff;
    logic                  full, empty, wr_en, rd_en;

    assign wsync = wq[num_stages-1];
    assign rsync = rq[num_stages-1];

    // The slot is the pointer mod DATA_DEPTH. A pointer is always below
    // 2*DATA_DEPTH, so one conditional subtract is enough.
    assign wslot = ADDR_WIDTH'((wptr >= PTR_DEPTH) ? wptr - PTR_DEPTH : wptr);
    assign rslot = ADDR_WIDTH'((rptr >= PTR_DEPTH) ? rptr - PTR_DEPTH : rptr);

    // Occupancy seen by the write side: (wptr - rsync) mod 2*DATA_DEPTH.
    always_comb begin
        diff = {1'b0, wptr} - {1'b0, rsync};
        if (wptr < rsync) diff = diff + DIFF_SPAN;
    end

    assign full  = (diff == DIFF_FULL);
    assign empty = (rptr == wsync);
    assign wr_en = bus.W_INC && !full;
    assign rd_en = bus.R_INC && !empty;

    assign bus.FULL    = full;
    assign bus.EMPTY   = empty;
    assign bus.RD_DATA = mem[rslot];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            if (rd_en) rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
        end
    end

    // Publish chains: stage 0 takes the live pointer, and the last stage is
    // the copy that the opposite side compares against.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < num_stages; i++) begin
                wq[i] <= '0;
                rq[i] <= '0;
            end
        end else begin
            wq[0] <= wptr;
            rq[0] <= rptr;
            for (int i = 1; i < num_stages; i++) begin
                wq[i] <= wq[i-1];
                rq[i] <= rq[i-1];
            end
        end
    end

    // Storage is cleared on reset so RD_DATA reads 0 while empty after reset.
    // A pop leaves the popped word in place.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DATA_DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wslot] <= bus.WR_DATA;
        end
    end
endmodule

// File: tb/tb_async_fifo.sv
module tb_async_fifo;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic clk_en = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    async_fifo_if #(.DATA_WIDTH(8)) bif ();

    async_fifo #(
        .ADDR_WIDTH(3), .ptr_width(4), .DATA_WIDTH(8), .DATA_DEPTH(6), .num_stages(2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bif.slave)
    );

    always #5 CLK = clk_en ? ~CLK : CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge. Outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int wi, ri, cyc;
        bif.W_INC   = 1'b0;
        bif.R_INC   = 1'b0;
        bif.WR_DATA = 8'h00;

        // Reset with no clock running.
        #3;
        chk("rst_empty", {31'd0, bif.EMPTY}, 32'd1);
        chk("rst_full",  {31'd0, bif.FULL},  32'd0);
        chk("rst_rdata", {24'd0, bif.RD_DATA}, 32'h00);
        RST = 1'b1;
        #2;
        clk_en = 1'b1;

        // Single write: EMPTY falls only after two publish edges.
        bif.W_INC = 1'b1; bif.WR_DATA = 8'hA5;
        step();
        bif.W_INC = 1'b0;
        chk("wr1_empty_k",  {31'd0, bif.EMPTY}, 32'd1);
        step();
        chk("wr1_empty_k1", {31'd0, bif.EMPTY}, 32'd1);
        step();
        chk("wr1_empty_k2", {31'd0, bif.EMPTY}, 32'd0);
        chk("wr1_rdata",    {24'd0, bif.RD_DATA}, 32'hA5);
        bif.R_INC = 1'b1;
        step();
        bif.R_INC = 1'b0;
        chk("rd1_empty", {31'd0, bif.EMPTY}, 32'd1);
        step(); step();

        // Nine writes with no reads: only the first six are stored.
        for (int i = 1; i <= 9; i++) begin
            bif.W_INC = 1'b1; bif.WR_DATA = 8'(i);
            step();
            if (i == 5) chk("fill_full_5", {31'd0, bif.FULL}, 32'd0);
            if (i == 6) chk("fill_full_6", {31'd0, bif.FULL}, 32'd1);
        end
        bif.W_INC = 1'b0;
        chk("fill_full_end",  {31'd0, bif.FULL},  32'd1);
        chk("fill_empty_end", {31'd0, bif.EMPTY}, 32'd0);

        // Seven reads: 01..06 in order, and the seventh read is ignored.
        bif.R_INC = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("drain_rdata_%0d", i), {24'd0, bif.RD_DATA}, 32'(i));
            step();
            if (i == 1) chk("drain_full_k",  {31'd0, bif.FULL}, 32'd1);
            if (i == 2) chk("drain_full_k1", {31'd0, bif.FULL}, 32'd1);
            if (i == 3) chk("drain_full_k2", {31'd0, bif.FULL}, 32'd0);
            if (i == 5) chk("drain_empty_5", {31'd0, bif.EMPTY}, 32'd0);
        end
        chk("drain_empty_6", {31'd0, bif.EMPTY}, 32'd1);
        step();
        bif.R_INC = 1'b0;
        chk("drain_empty_7", {31'd0, bif.EMPTY}, 32'd1);
        step(); step();

        // Interleaved traffic 10..1D across slot and pointer wrap.
        // Writes are gated on FULL, so none of these words is dropped.
        wi = 0; ri = 0; cyc = 0;
        while (ri < 14 && cyc < 300) begin
            bif.W_INC   = (wi < 14) && (cyc % 3 != 2) && !bif.FULL;
            bif.WR_DATA = 8'(8'h10 + wi);
            bif.R_INC   = (cyc % 2 == 0) && !bif.EMPTY;
            if (bif.R_INC) begin
                chk($sformatf("mix_rdata_%0d", ri), {24'd0, bif.RD_DATA}, 32'(8'h10 + ri));
                ri++;
            end
            if (bif.W_INC) wi++;
            step();
            cyc++;
        end
        bif.W_INC = 1'b0; bif.R_INC = 1'b0;
        chk("mix_reads_done", 32'(ri), 32'd14);
        step(); step();
        chk("mix_empty_end", {31'd0, bif.EMPTY}, 32'd1);

        // Queue three words, then pulse reset between clock edges.
        for (int i = 0; i < 3; i++) begin
            bif.W_INC = 1'b1; bif.WR_DATA = 8'(8'h20 + i);
            step();
        end
        bif.W_INC = 1'b0;
        step(); step();
        chk("pre_rst_empty", {31'd0, bif.EMPTY}, 32'd0);
        #1 RST = 1'b0;
        #1;
        chk("mid_rst_empty", {31'd0, bif.EMPTY}, 32'd1);
        chk("mid_rst_full",  {31'd0, bif.FULL},  32'd0);
        chk("mid_rst_rdata", {24'd0, bif.RD_DATA}, 32'h00);
        #1 RST = 1'b1;
        bif.W_INC = 1'b1; bif.WR_DATA = 8'h3C;
        step();
        bif.W_INC = 1'b0;
        step(); step();
        chk("post_rst_empty", {31'd0, bif.EMPTY}, 32'd0);
        chk("post_rst_rdata", {24'd0, bif.RD_DATA}, 32'h3C);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
